// File: rtl/instruction_loader.sv
// Serial program loader: frames bytes into 32-bit big-endian words and
// writes them to instruction memory, holding the CPU until a verified load.
module instruction_loader #(
   parameter int         width_B    = 32,
   parameter int         Addr_B     = 10,
   parameter logic [7:0] START_BYTE = 8'hA5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic                imem_we,
   output logic [Addr_B-1:0]   imem_addr,
   output logic [width_B-1:0]  imem_wdata,
   output logic                cpu_hold,
   output logic                load_done,
   output logic                load_error,
   output logic [Addr_B:0]     words_loaded
);

   typedef enum logic [2:0] {
      IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE, ERROR
   } state_t;

   localparam logic [16:0] MAX_WORDS = 17'(1) << Addr_B;

   state_t             state;
   logic [7:0]         count_hi;
   logic [15:0]        count;
   logic [1:0]         byte_idx;
   logic [7:0]         chk;
   logic [width_B-9:0] word_sr;

   logic [15:0]        cnt_full;
   logic [width_B-1:0] next_word;
   logic [15:0]        next_words;

   assign cnt_full   = {count_hi, rx_data};
   assign next_word  = {word_sr, rx_data};
   assign next_words = 16'(words_loaded) + 16'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         count_hi     <= '0;
         count        <= '0;
         byte_idx     <= '0;
         chk          <= '0;
         word_sr      <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         cpu_hold     <= 1'b1;
         load_done    <= 1'b0;
         load_error   <= 1'b0;
         words_loaded <= '0;
      end else begin
         imem_we <= 1'b0;
         // address moves on only after the write cycle has used it
         if (imem_we)
            imem_addr <= imem_addr + Addr_B'(1);
         if (rx_valid) begin
            unique case (state)
               IDLE, DONE, ERROR: begin
                  if (rx_data == START_BYTE) begin
                     state        <= CNT_HI;
                     load_done    <= 1'b0;
                     load_error   <= 1'b0;
                     cpu_hold     <= 1'b1;
                     imem_addr    <= '0;
                     byte_idx     <= '0;
                     chk          <= '0;
                     words_loaded <= '0;
                  end
               end
               CNT_HI: begin
                  count_hi <= rx_data;
                  state    <= CNT_LO;
               end
               CNT_LO: begin
                  count <= cnt_full;
                  if (cnt_full == 16'd0) begin
                     state <= CHECK;
                  end else if ({1'b0, cnt_full} > MAX_WORDS) begin
                     state      <= ERROR;
                     load_error <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
               DATA: begin
                  word_sr  <= next_word[width_B-9:0];
                  chk      <= chk ^ rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     imem_we      <= 1'b1;
                     imem_wdata   <= next_word;
                     words_loaded <= words_loaded + (Addr_B+1)'(1);
                     if (next_words == count)
                        state <= CHECK;
                  end
               end
               CHECK: begin
                  if (rx_data == chk) begin
                     state     <= DONE;
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end else begin
                     state      <= ERROR;
                     load_error <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
